// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types, constants and helpers for the PCM reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam logic [7:0] RATE_MAX = 8'd128;

    // Gain index 0 (mute) .. 15 (unity = 128); entry [i] is the gain for volume i.
    localparam logic [15:0][7:0] VOLUME_LUT = {
        8'd128, 8'd64, 8'd45, 8'd32, 8'd24, 8'd18, 8'd14, 8'd11,
        8'd8,   8'd6,  8'd5,  8'd4,  8'd3,  8'd2,  8'd1,  8'd0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SCALE = 2'd2
    } pcm_state_t;

    function automatic logic [2:0] pcm_bytes(input logic stereo, input logic b16);
        case ({stereo, b16})
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_volume_scale.sv
`default_nettype none
// ============================================================================
//  Module      : audio_volume_scale
//  Description : Signed 16-bit sample times unsigned 8-bit gain, >>> 7.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_volume_scale (
    input  logic signed [15:0] sample,
    input  logic        [7:0]  gain,
    output logic        [15:0] scaled
);

    logic signed [24:0] w_prod;
    logic               w_unused_prod;

    // Gain never exceeds 128, so bits [22:7] always hold the full result.
    assign w_prod        = sample * $signed({1'b0, gain});
    assign scaled        = w_prod[22:7];
    assign w_unused_prod = ^{w_prod[24:23], w_prod[6:0]};

endmodule
`default_nettype wire

// File: rtl/audio_pcm_reader.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pcm_reader
//  Description : Rate-paced PCM fetch from the audio FIFO with log volume.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pcm_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_sample,
    input  logic [7:0]  sample_rate,
    input  logic        mode_stereo,
    input  logic        mode_16bit,
    input  logic [3:0]  volume,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic        sample_stb,
    output logic        underrun
);

    import audio_pkg::*;

    pcm_state_t       r_state;
    pcm_state_t       w_state_next;

    logic [7:0]       r_acc;
    logic [7:0]       w_rate;
    logic [7:0]       w_acc_sum;
    logic             w_fetch_req;
    logic             w_unused_acc_msb;

    logic [2:0]       r_k;
    logic [2:0]       r_n;
    logic             r_stereo;
    logic             r_b16;
    logic             r_abort;
    logic             r_cap_pend;
    logic [1:0]       r_cap_idx;
    logic [3:0][7:0]  r_bytes;
    logic [3:0][7:0]  w_byte;

    logic             w_need_byte;
    logic             w_abort_now;
    logic             w_last_pop;

    logic [15:0]      w_raw_l;
    logic [15:0]      w_raw_r;
    logic [15:0]      w_scaled_l;
    logic [15:0]      w_scaled_r;
    logic [7:0]       w_gain;

    logic [15:0]      r_left;
    logic [15:0]      r_right;
    logic             r_sample_stb;
    logic             r_underrun;

    // ------------------------------------------------------------------
    // Rate accumulator: bit 7 of the new value is the fetch carry.
    // ------------------------------------------------------------------
    assign w_rate           = (sample_rate > RATE_MAX) ? RATE_MAX : sample_rate;
    assign w_acc_sum        = {1'b0, r_acc[6:0]} + w_rate;
    assign w_fetch_req      = next_sample && w_acc_sum[7];
    assign w_unused_acc_msb = r_acc[7];

    // ------------------------------------------------------------------
    // FIFO handshake
    // ------------------------------------------------------------------
    assign w_need_byte = (r_state == FETCH) && (r_k < r_n);
    assign fifo_rd_en  = w_need_byte && !fifo_empty;
    assign w_abort_now = w_need_byte && fifo_empty;
    assign w_last_pop  = fifo_rd_en && (r_k == (r_n - 3'd1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fetch_req) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (w_abort_now || w_last_pop || !w_need_byte) begin
                    w_state_next = SCALE;
                end
            end
            SCALE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch bookkeeping and byte capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_k        <= '0;
            r_n        <= 3'd1;
            r_stereo   <= 1'b0;
            r_b16      <= 1'b0;
            r_abort    <= 1'b0;
            r_cap_pend <= 1'b0;
            r_cap_idx  <= '0;
            r_bytes    <= '0;
        end else begin
            if (next_sample) begin
                r_acc <= w_acc_sum;
            end
            if ((r_state == IDLE) && w_fetch_req) begin
                r_k      <= '0;
                r_n      <= pcm_bytes(mode_stereo, mode_16bit);
                r_stereo <= mode_stereo;
                r_b16    <= mode_16bit;
                r_abort  <= 1'b0;
            end else begin
                if (fifo_rd_en) begin
                    r_k <= r_k + 3'd1;
                end
                if (w_abort_now) begin
                    r_abort <= 1'b1;
                end
            end
            r_cap_pend <= fifo_rd_en;
            r_cap_idx  <= r_k[1:0];
            if (r_cap_pend) begin
                r_bytes[r_cap_idx] <= fifo_rddata;
            end
        end
    end

    // The final byte is still on fifo_rddata during SCALE, so bypass it in.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_bypass
        assign w_byte[gi] = (r_cap_pend && (r_cap_idx == gi[1:0])) ? fifo_rddata : r_bytes[gi];
    end

    always_comb begin
        w_raw_l = '0;
        w_raw_r = '0;
        if (!r_abort) begin
            if (r_b16) begin
                w_raw_l = {w_byte[1], w_byte[0]};
            end else begin
                w_raw_l = {w_byte[0], 8'h00};
            end
            if (!r_stereo) begin
                w_raw_r = w_raw_l;
            end else if (r_b16) begin
                w_raw_r = {w_byte[3], w_byte[2]};
            end else begin
                w_raw_r = {w_byte[1], 8'h00};
            end
        end
    end

    // ------------------------------------------------------------------
    // Volume scaling and registered outputs
    // ------------------------------------------------------------------
    assign w_gain = VOLUME_LUT[volume];

    audio_volume_scale u_scale_l (
        .sample (w_raw_l),
        .gain   (w_gain),
        .scaled (w_scaled_l)
    );

    audio_volume_scale u_scale_r (
        .sample (w_raw_r),
        .gain   (w_gain),
        .scaled (w_scaled_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_left       <= '0;
            r_right      <= '0;
            r_sample_stb <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_sample_stb <= (r_state == SCALE);
            r_underrun   <= ((r_state == SCALE) && r_abort) ||
                            ((r_state != IDLE) && w_fetch_req);
            if (r_state == SCALE) begin
                r_left  <= w_scaled_l;
                r_right <= w_scaled_r;
            end
        end
    end

    assign left_out   = r_left;
    assign right_out  = r_right;
    assign sample_stb = r_sample_stb;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire
